// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives the async program ROM and queues {word, pc} pairs for decode.
module fetch_unit #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_data,
  output logic              ir_valid,
  output logic [DWIDTH-1:0] ir_data,
  output logic [AWIDTH-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              br_valid,
  input  logic [AWIDTH-1:0] br_target,
  input  logic              stall
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {RUN, HOLD} fetch_state_e;
  fetch_state_e state;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic pop, push;
  assign rom_addr = pc_q;
  assign ir_valid = count_q != '0;
  assign ir_data = data_q[rd_ptr_q];
  assign ir_pc = addr_q[rd_ptr_q];
  // HOLD is decided in the same cycle so a full FIFO that pops still refills without a bubble
  always_comb begin
    pop = ir_valid & ir_ready & ~br_valid;
    state = (stall | ((count_q == CW'(DEPTH)) & ~pop)) ? HOLD : RUN;
    push = ~br_valid & (state == RUN);
    pc_d = br_valid ? br_target : pc_q + AWIDTH'(push);
    rd_ptr_d = br_valid ? wr_ptr_q : rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d = br_valid ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      pc_q <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      data_q[wr_ptr_q] <= rom_data;
      addr_q[wr_ptr_q] <= pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, wrap check on a second instance, and random run against a queue model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset, ir_ready, br_valid, stall;
  logic [7:0] br_target, rom_addr, ir_pc, rom_addr2, ir_pc2;
  logic [15:0] rom_data, ir_data, rom_data2, ir_data2;
  logic ir_valid, ir_valid2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  assign rom_data = 16'h1000 + 16'(rom_addr);
  assign rom_data2 = 16'h1000 + 16'(rom_addr2);

  fetch_unit dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .br_valid(br_valid), .br_target(br_target), .stall(stall)
  );

  fetch_unit #(.RESET_PC(8'hFE)) dut2 (
    .clk(clk), .reset(reset), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .ir_valid(ir_valid2), .ir_data(ir_data2), .ir_pc(ir_pc2), .ir_ready(1'b1),
    .br_valid(1'b0), .br_target(8'h00), .stall(1'b0)
  );

  typedef struct {
    logic rst, rdy, stl, br;
    logic [7:0] tgt;
    logic ev;
    logic [7:0] epc, eaddr;
  } vec_t;
  vec_t tbl [26];

  logic [15:0] mq_data [$];
  logic [7:0] mq_pc [$];
  logic [7:0] mpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic v(input int i, input logic rst, rdy, stl, br, input logic [7:0] tgt,
                   input logic ev, input logic [7:0] epc, eaddr);
    tbl[i] = '{rst, rdy, stl, br, tgt, ev, epc, eaddr};
  endtask

  task automatic drive(input logic rst, rdy, stl, br, input logic [7:0] tgt);
    reset = rst; ir_ready = rdy; stall = stl; br_valid = br; br_target = tgt;
  endtask

  // Reference: a FIFO of at most two fetched words, updated once per clock from the rules
  task automatic model_step(input logic rst, rdy, stl, br, input logic [7:0] tgt);
    bit do_pop, do_push;
    if (rst) begin
      mq_data.delete(); mq_pc.delete(); mpc = 8'h00;
    end else if (br) begin
      mq_data.delete(); mq_pc.delete(); mpc = tgt;
    end else begin
      do_pop = (mq_pc.size() > 0) && rdy;
      do_push = !stl && (mq_pc.size() < 2 || do_pop);
      if (do_pop) begin
        void'(mq_data.pop_front()); void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_data.push_back(16'h1000 + 16'(mpc)); mq_pc.push_back(mpc); mpc = mpc + 8'd1;
      end
    end
  endtask

  initial begin
    v(0, 0,0,0,0,8'h00, 0,8'h00,8'h00);
    v(1, 0,0,0,0,8'h00, 1,8'h00,8'h01);
    v(2, 0,0,0,0,8'h00, 1,8'h00,8'h02);
    v(3, 0,0,0,0,8'h00, 1,8'h00,8'h02);
    v(4, 0,0,0,0,8'h00, 1,8'h00,8'h02);
    v(5, 0,1,0,0,8'h00, 1,8'h00,8'h02);
    v(6, 0,1,0,0,8'h00, 1,8'h01,8'h03);
    v(7, 0,1,0,0,8'h00, 1,8'h02,8'h04);
    v(8, 0,1,0,0,8'h00, 1,8'h03,8'h05);
    v(9, 0,1,0,1,8'h40, 1,8'h04,8'h06);
    v(10,0,1,0,0,8'h00, 0,8'h00,8'h40);
    v(11,0,1,0,0,8'h00, 1,8'h40,8'h41);
    v(12,0,1,1,0,8'h00, 1,8'h41,8'h42);
    v(13,0,1,1,0,8'h00, 0,8'h00,8'h42);
    v(14,0,1,1,0,8'h00, 0,8'h00,8'h42);
    v(15,0,1,0,0,8'h00, 0,8'h00,8'h42);
    v(16,0,1,0,0,8'h00, 1,8'h42,8'h43);
    v(17,0,1,1,1,8'h80, 1,8'h43,8'h44);
    v(18,0,1,1,0,8'h00, 0,8'h00,8'h80);
    v(19,0,1,0,0,8'h00, 0,8'h00,8'h80);
    v(20,0,1,0,0,8'h00, 1,8'h80,8'h81);
    v(21,0,0,0,0,8'h00, 1,8'h81,8'h82);
    v(22,0,0,0,0,8'h00, 1,8'h81,8'h83);
    v(23,1,1,0,1,8'h55, 1,8'h81,8'h83);
    v(24,0,1,0,0,8'h00, 0,8'h00,8'h00);
    v(25,0,1,0,0,8'h00, 1,8'h00,8'h01);

    drive(1, 0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].rst, tbl[k].rdy, tbl[k].stl, tbl[k].br, tbl[k].tgt);
      chk($sformatf("vec%0d valid", k), 32'(ir_valid), 32'(tbl[k].ev));
      chk($sformatf("vec%0d rom_addr", k), 32'(rom_addr), 32'(tbl[k].eaddr));
      if (tbl[k].ev) begin
        chk($sformatf("vec%0d ir_pc", k), 32'(ir_pc), 32'(tbl[k].epc));
        chk($sformatf("vec%0d ir_data", k), 32'(ir_data), 32'(16'h1000 + 16'(tbl[k].epc)));
      end
      if (k == 0) chk("wrap valid0", 32'(ir_valid2), 32'd0);
      if (k >= 1 && k <= 4) begin
        chk($sformatf("wrap%0d valid", k), 32'(ir_valid2), 32'd1);
        chk($sformatf("wrap%0d ir_pc", k), 32'(ir_pc2), 32'(8'(8'hFE + 8'(k - 1))));
      end
      @(negedge clk);
    end

    drive(1, 0, 0, 0, 8'h00);
    model_step(1, 0, 0, 0, 8'h00);
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      logic rst, rdy, stl, br;
      logic [7:0] tgt;
      rst = ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 9) == 0);
      tgt = 8'($urandom);
      drive(rst, rdy, stl, br, tgt);
      chk("rnd valid", 32'(ir_valid), 32'(mq_pc.size() != 0));
      chk("rnd rom_addr", 32'(rom_addr), 32'(mpc));
      if (mq_pc.size() != 0) begin
        chk("rnd ir_pc", 32'(ir_pc), 32'(mq_pc[0]));
        chk("rnd ir_data", 32'(ir_data), 32'(mq_data[0]));
      end
      @(posedge clk);
      model_step(rst, rdy, stl, br, tgt);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly downstream of the asynchronous-read program ROM. It owns the program counter, drives the ROM address, and captures the returned word together with its PC into a small prefetch FIFO. It presents instructions to decode with a valid/ready handshake and supports a branch redirect that flushes all prefetched words.

Parameters:
DWIDTH, 16, instruction word width; must match the ROM data width.
AWIDTH, 8, PC/ROM address width; the PC wraps modulo 2**AWIDTH.
DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
rom_addr  output  AWIDTH  ROM address; always equals the current PC register.
rom_data  input  DWIDTH  ROM read data; combinational from rom_addr in the same cycle.
ir_valid  output  1  head FIFO entry is valid.
ir_data  output  DWIDTH  instruction word at the FIFO head.
ir_pc  output  AWIDTH  address the head word was fetched from.
ir_ready  input  1  decode accepts the head entry this cycle.
br_valid  input  1  redirect request.
br_target  input  AWIDTH  redirect PC.
stall  input  1  suppress new fetches; pops still occur.

Behaviour:
- Reset: pc<=RESET_PC; FIFO empty (rd_ptr=wr_ptr=count=0). ir_valid=0. ir_data and ir_pc are don't-care while ir_valid=0. Reset overrides every other input.
- pop = ir_valid & ir_ready & ~br_valid.
- push = ~br_valid & ~stall & (count<DEPTH | pop). A push writes {rom_data, pc} at wr_ptr, and pc<=pc+1 (AWIDTH-bit wrap, e.g. 8'hFF -> 8'h00).
- Full FIFO with a same-cycle pop: the push is allowed and count is unchanged.
- Empty FIFO: ir_valid=0. No bypass: a pushed word becomes visible the cycle after it is pushed.
- Latency: the first cycle after reset drops pushes addr RESET_PC; ir_valid=1 on the following cycle. Sustained throughput is 1 word/cycle when ir_ready=1 and stall=0.
- count<=count+push-pop. Pointers are log2(DEPTH) bits and wrap naturally. ir_valid=(count!=0). ir_data/ir_pc are read from rd_ptr.
- Redirect (br_valid=1) has priority over push and pop:
  - FIFO is flushed (count<=0, rd_ptr<=wr_ptr) and pc<=br_target.
  - No push occurs. Any head entry is discarded even if ir_ready=1.
  - The next cycle fetches br_target; the cycle after that gives ir_valid=1 with ir_pc=br_target.
- br_valid and stall together: the redirect is still taken.
- Redirect during stall: pc updates and fetch resumes only when stall drops.
- Reset asserted mid-stream: all prefetched entries are lost and the sequence restarts from RESET_PC.
- Fetch control has two states. RUN means pushes are permitted. HOLD is entered whenever the FIFO is full with no pop, or stall=1; rom_addr holds the PC steady while in HOLD. The transition is purely combinational on the conditions above. No extra pipeline bubbles are permitted.

Test Plan:
- Reset, ir_ready=1, ROM preloaded with word[i]=16'h1000+i -> from cycle 2 after reset, ir_valid=1 every cycle with ir_pc=0,1,2,… and ir_data=16'h1000,16'h1001,….
- ir_ready=0 for 5 cycles after reset -> count saturates at DEPTH=2; rom_addr holds at 2; ir_pc stays 0; then ir_ready=1 -> ir_pc sequence 0,1,2,3 with no gap and no duplicate.
- br_valid=1 with br_target=8'h40 while the FIFO holds 2 entries and ir_ready=1 -> both entries dropped; ir_valid=0 for 1 cycle; next word ir_pc=8'h40, ir_data=16'h1040.
- RESET_PC=8'hFE, free-running -> ir_pc sequence FE, FF, 00, 01 (wrap, no stall).
- stall=1 for 3 cycles mid-stream with ir_ready=1 -> FIFO drains to ir_valid=0; rom_addr constant; resume on stall=0 with a contiguous ir_pc.
- reset pulsed for 1 cycle while full and br_valid=1 -> ir_valid=0 the next cycle; fetch restarts at RESET_PC and the redirect is ignored.
